// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-stage types and constants
package rv_pkg;
  typedef enum logic {FETCH, FAULT} fetch_state_t;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam int INST_BYTES = 4;
endpackage

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID output register with redirect flush and sticky fault
module fetch_unit
  import rv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int MEM_BYTES = 1024
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [ILEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [31:0]     fetch_count
);
  localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_BYTES - INST_BYTES);
  fetch_state_t state;
  logic [XLEN-1:0] pc_q;
  logic can_load;
  logic xfer;
  function automatic logic bad(input logic [XLEN-1:0] a);
    return (a[1:0] != 2'b00) || (a > LAST_PC);
  endfunction
  assign imem_pc  = pc_q;
  assign xfer     = out_valid && out_ready;
  assign can_load = (state == FETCH) && (!out_valid || out_ready);
  // redirect beats a pending load; a bad address parks the stage in FAULT until reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      pc_q        <= RESET_PC;
      out_valid   <= 1'b0;
      out_inst    <= ILEN'(NOP_INST);
      out_pc      <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
      fetch_count <= '0;
    end else begin
      if (xfer) fetch_count <= fetch_count + 32'd1;
      if (state == FETCH) begin
        if (redirect_valid) begin
          out_valid <= 1'b0;
          if (bad(redirect_pc)) begin
            state    <= FAULT;
            fault    <= 1'b1;
            fault_pc <= redirect_pc;
          end else begin
            pc_q <= redirect_pc;
          end
        end else if (can_load && bad(pc_q)) begin
          state     <= FAULT;
          fault     <= 1'b1;
          fault_pc  <= pc_q;
          out_valid <= 1'b0;
        end else if (can_load) begin
          out_inst  <= imem_inst;
          out_pc    <= pc_q;
          out_valid <= 1'b1;
          pc_q      <= pc_q + XLEN'(INST_BYTES);
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: vector table plus transfer scoreboard for fetch_unit
module tb_fetch_unit;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] imem;
    logic        f;
    logic [31:0] fpc;
    logic [31:0] cnt;
  } vec_t;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } xfer_t;
  vec_t  tbl[$];
  xfer_t sb[$];
  fetch_unit #(.XLEN(32), .ILEN(32), .RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clock(clock), .reset(reset), .imem_pc(imem_pc), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] w(input logic [31:0] a);
    return a == 32'd0 ? 32'h11 : a == 32'd4 ? 32'h22 : a == 32'd8 ? 32'h33 : {16'hC0DE, a[15:0]};
  endfunction
  assign imem_inst = w(imem_pc);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic rdy);
    xfer_t e;
    reset = r;
    redirect_valid = rv;
    redirect_pc = rpc;
    out_ready = rdy;
    #1;
    if (out_valid === 1'b1 && out_ready && !reset) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL xfer_unexpected: got pc %h, scoreboard empty", out_pc);
      end else begin
        e = sb.pop_front();
        check("xfer_pc", out_pc, e.pc);
        check("xfer_inst", out_inst, e.inst);
      end
    end
    @(posedge clock);
    #1;
  endtask
  task automatic chk_row(input vec_t x, input int i);
    check($sformatf("r%0d_valid", i), {31'b0, out_valid}, {31'b0, x.v});
    check($sformatf("r%0d_out_pc", i), out_pc, x.pc);
    check($sformatf("r%0d_out_inst", i), out_inst, x.inst);
    check($sformatf("r%0d_imem_pc", i), imem_pc, x.imem);
    check($sformatf("r%0d_fault", i), {31'b0, fault}, {31'b0, x.f});
    check($sformatf("r%0d_fault_pc", i), fault_pc, x.fpc);
    check($sformatf("r%0d_count", i), fetch_count, x.cnt);
  endtask
  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    tbl.push_back('{1, 0, 0, 1, 0, 0, NOP, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 32'h11, 4, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 8, 32'h33, 12, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 1, 1, 12, w(12), 16, 0, 0, 3});
    tbl.push_back('{1, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 32'h11, 4, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 0, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{0, 0, 0, 1, 1, 8, 32'h33, 12, 0, 0, 2});
    tbl.push_back('{0, 0, 0, 1, 1, 12, w(12), 16, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 1, 12, w(12), 16, 0, 0, 3});
    tbl.push_back('{0, 1, 32'h100, 0, 0, 12, w(12), 32'h100, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 0, 1, 32'h100, w(32'h100), 32'h104, 0, 0, 3});
    tbl.push_back('{0, 0, 0, 1, 1, 32'h104, w(32'h104), 32'h108, 0, 0, 4});
    tbl.push_back('{0, 1, 32'h102, 1, 0, 32'h104, w(32'h104), 32'h108, 1, 32'h102, 5});
    tbl.push_back('{0, 1, 32'h0, 1, 0, 32'h104, w(32'h104), 32'h108, 1, 32'h102, 5});
    tbl.push_back('{0, 0, 32'h0, 1, 0, 32'h104, w(32'h104), 32'h108, 1, 32'h102, 5});
    tbl.push_back('{1, 1, 32'h200, 0, 0, 0, NOP, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 0, 32'h11, 4, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 1, 4, 32'h22, 8, 0, 0, 1});
    tbl.push_back('{1, 1, 32'h300, 0, 0, 0, NOP, 0, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 0, 32'h11, 4, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h400, 0, 0, 0, 32'h11, 4, 1, 32'h400, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h3FC, 0, 0, 0, NOP, 32'h3FC, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 32'h3FC, w(32'h3FC), 32'h400, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 1, 0, 32'h3FC, w(32'h3FC), 32'h400, 1, 32'h400, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0, NOP, 0, 0, 0, 0});
    foreach (tbl[i]) begin
      if (i > 0 && tbl[i].rdy && !tbl[i].rst && tbl[i-1].v)
        sb.push_back('{tbl[i-1].pc, tbl[i-1].inst});
      cyc(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].rdy);
      chk_row(tbl[i], i);
    end
    cyc(0, 0, 0, 1);
    check("run_first_pc", out_pc, 32'h0);
    for (int k = 1; k < 256; k++) begin
      sb.push_back('{32'((k - 1) * 4), w(32'((k - 1) * 4))});
      cyc(0, 0, 0, 1);
    end
    check("run_last_valid", {31'b0, out_valid}, 32'd1);
    check("run_last_pc", out_pc, 32'h3FC);
    sb.push_back('{32'h3FC, w(32'h3FC)});
    cyc(0, 0, 0, 1);
    check("run_fault", {31'b0, fault}, 32'd1);
    check("run_fault_pc", fault_pc, 32'h400);
    check("run_valid_off", {31'b0, out_valid}, 32'd0);
    check("run_count", fetch_count, 32'd256);
    cyc(0, 0, 0, 1);
    check("run_fault_sticky", {31'b0, fault}, 32'd1);
    check("run_pc_frozen", imem_pc, 32'h400);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's byte address. Captures the combinationally-read instruction into an IF/ID output register with a valid/ready handshake to decode.
- Handles redirects (branch/jump/trap) with flush, and enters a sticky fault state on misaligned or out-of-range fetch addresses.

Parameters:
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- RESET_PC, 0, PC value after reset
- MEM_BYTES, 1024, instruction memory size in bytes; valid fetch addresses are 0..MEM_BYTES-4

Ports:
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high reset
- imem_pc  output  XLEN  byte address to instruction memory; always equals pc_q
- imem_inst  input  ILEN  instruction read combinationally at imem_pc, same cycle
- redirect_valid  input  1  load new PC this cycle, flush output register
- redirect_pc  input  XLEN  redirect target
- out_valid  output  1  IF/ID register holds an instruction
- out_ready  input  1  decode accepts; transfer when out_valid && out_ready
- out_inst  output  ILEN  fetched instruction
- out_pc  output  XLEN  address of out_inst
- fault  output  1  sticky fetch fault
- fault_pc  output  XLEN  offending address
- fetch_count  output  32  number of completed output transfers, wraps modulo 2^32

Behaviour:
- Reset (synchronous, sampled at clock edge):
  - state=FETCH, pc_q=RESET_PC
  - out_valid=0, out_inst=NOP (0x00000013), out_pc=0
  - fault=0, fault_pc=0, fetch_count=0
  - reset overrides every other input, including mid-fault and mid-stall.
- States: FETCH, FAULT.
- bad(a) = (a[1:0]!=0) || (a > MEM_BYTES-4), unsigned compare.
- can_load = (state==FETCH) && (!out_valid || out_ready).
- Priority, evaluated each edge in FETCH:
  1. redirect_valid:
     - if bad(redirect_pc): state<=FAULT, fault<=1, fault_pc<=redirect_pc, out_valid<=0.
     - else: pc_q<=redirect_pc, out_valid<=0.
     - The current imem_inst is discarded.
  2. else if can_load && bad(pc_q): state<=FAULT, fault<=1, fault_pc<=pc_q, out_valid<=0.
  3. else if can_load: out_inst<=imem_inst, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+4 (XLEN-bit wrap).
  4. else (out_valid && !out_ready): hold pc_q and the output register unchanged.
- Output transfer (out_valid && out_ready) increments fetch_count in the same edge, even if a redirect also occurs that cycle. The transferred instruction counts as consumed.
- FAULT:
  - out_valid=0, pc_q frozen, fault=1.
  - redirect_valid and out_ready are ignored.
  - Exit only via reset.
- Latency:
  - First out_valid=1 appears one edge after reset deasserts.
  - Redirect asserted before edge N: out_valid=0 after N, instruction at redirect_pc valid after N+1.
  - Throughput is one instruction per cycle with out_ready held high.
- imem_pc is combinational from pc_q only, never from redirect_pc. This gives no combinational path from redirect inputs to the memory.
- Output register is stable while out_valid && !out_ready. out_inst/out_pc retain their last values when out_valid=0.

Decomposition:
- Shared package rv_pkg:
  - fetch_state_t enum {FETCH, FAULT}
  - constant NOP_INST = 32'h0000_0013
  - constant INST_BYTES = 4
- No sub-module. PC register, output register and state are small enough for one module.

Test Plan:
- Reset with RESET_PC=0, memory words 0x11,0x22,0x33 at 0/4/8, out_ready=1 -> out_pc 0,4,8 on consecutive cycles; out_inst 0x11,0x22,0x33; fetch_count=3.
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 at pc 4 -> out_inst/out_pc/imem_pc stable (out_pc=4, imem_pc=8); release -> 8 then 12 follow with no gap or duplicate.
- Redirect to 0x100 while out_valid=1, out_ready=0 -> next cycle out_valid=0 and imem_pc=0x100; following cycle out_pc=0x100; fetch_count unchanged.
- Redirect to 0x102 -> fault=1, fault_pc=0x102, out_valid=0 permanently; later redirect to 0x0 is ignored; reset clears fault and restarts at RESET_PC.
- Sequential run off the end, MEM_BYTES=1024, out_ready=1 -> last valid out_pc=0x3FC, then fault=1 with fault_pc=0x400.
- Reset asserted mid-stream during a redirect cycle -> all outputs take reset values at that edge, and the redirect has no effect.
